// File: rtl/rca_mult_seq_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state encoding
// and default operand width.
package rca_mult_seq_pkg;
  localparam int DEF_WIDTH = 4;

  // 2'd3 is unused and decodes back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/rca_mult_dp.sv
// Multiplier datapath: M/Q/ACC registers, the adder operand muxing, the
// shift of {cout,sum,Q}, and the product register.
module rca_mult_dp
  import rca_mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               calc,
  input  logic               last,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic [2*WIDTH-1:0] product
);
  logic [WIDTH-1:0]   m_q, q_q, acc_q;
  logic [WIDTH-1:0]   acc_d, q_d;
  logic [2*WIDTH-1:0] product_q;

  // Operands are forced to zero outside CALC so the adder stays quiet.
  assign add_a = calc ? acc_q : '0;
  assign add_b = (calc && q_q[0]) ? m_q : '0;

  assign acc_d   = {add_cout, add_sum[WIDTH-1:1]};
  assign q_d     = {add_sum[0], q_q[WIDTH-1:1]};
  assign product = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (load) begin
      m_q   <= a_in;
      q_q   <= b_in;
      acc_q <= '0;
    end else if (calc) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      if (last) product_q <= {acc_d, q_d};
    end
  end
endmodule

// File: rtl/rca_mult_seq.sv
// Shift-add unsigned multiplier sequencer driving an external combinational
// ripple-carry adder; one multiplier bit retired per clock.
module rca_mult_seq
  import rca_mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load, calc, last;

  assign calc    = (state_q == S_CALC);
  assign load    = (state_q == S_IDLE) && start;
  assign last    = calc && (cnt_q == CNT_W'(WIDTH-1));
  assign busy    = calc;
  assign done    = (state_q == S_DONE);
  assign add_cin = 1'b0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CALC;
        cnt_d   = '0;
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  rca_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .calc     (calc),
    .last     (last),
    .a_in     (a_in),
    .b_in     (b_in),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .product  (product)
  );
endmodule

// File: tb/tb_rca_mult_seq.sv
// Directed bench for rca_mult_seq with a behavioural ripple-carry adder
// attached to the adder port.
module tb_rca_mult_seq;
  localparam int W = 4;

  logic           clk, rst_n, start;
  logic [W-1:0]   a_in, b_in;
  logic           busy, done, add_cin, add_cout;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a, add_b, add_sum;

  int total = 0;
  int bad   = 0;

  rca_mult_seq #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one op from IDLE; returns at the negedge after the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit chk_addb, output logic [2*W-1:0] p,
                        output int lat, output int nbusy);
    logic [2*W-1:0] prev;
    prev = product;
    lat = 0; nbusy = 0; p = '0;
    @(negedge clk); a_in = a; b_in = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      total++;
      if (busy && done) begin bad++; $display("FAIL busy_done_overlap k=%0d", k); end
      if (done) begin lat = k; p = product; break; end
      if (busy) begin
        nbusy++;
        total++;
        if (product !== prev) begin
          bad++; $display("FAIL prod_hold got=%0d want=%0d", product, prev);
        end
        if (chk_addb) begin
          total++;
          if (add_b !== '0) begin bad++; $display("FAIL add_b_zero got=%0h want=0", add_b); end
        end
      end
      @(negedge clk);
    end
    total++;
    if (lat == 0) begin bad++; $display("FAIL timeout a=%0d b=%0d no done", a, b); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_once done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, product, add_a, add_b, add_cin} !== '0) begin
      bad++; $display("FAIL reset_outs got=%b/%b/%0d/%0h/%0h/%b want all 0",
                      busy, done, product, add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p; int lat, nb;
    run_op(4'b0111, 4'b1001, 1'b0, p, lat, nb);
    total++; if (p !== 8'd63) begin bad++; $display("FAIL basic_prod got=%0d want=63", p); end
    total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", lat); end
    total++; if (nb !== 4) begin bad++; $display("FAIL basic_busy got=%0d want=4", nb); end
    total++; if (add_a !== '0 || add_b !== '0) begin
      bad++; $display("FAIL idle_adder got=%0h/%0h want 0/0", add_a, add_b);
    end
  endtask

  task automatic test_max();
    logic [2*W-1:0] p; int lat, nb;
    run_op(4'b1111, 4'b1111, 1'b0, p, lat, nb);
    total++; if (p !== 8'd225) begin bad++; $display("FAIL max_prod got=%0d want=225", p); end
  endtask

  task automatic test_zero();
    logic [2*W-1:0] p; int lat, nb;
    run_op(4'b1010, 4'b0000, 1'b1, p, lat, nb);
    total++; if (p !== 8'd0) begin bad++; $display("FAIL zero_b_prod got=%0d want=0", p); end
    run_op(4'b0000, 4'b1101, 1'b0, p, lat, nb);
    total++; if (p !== 8'd0) begin bad++; $display("FAIL zero_a_prod got=%0d want=0", p); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [2*W-1:0] p1, p2;
    d1 = 0; d2 = 0; p1 = '0; p2 = '0;
    @(negedge clk); a_in = 4'b0011; b_in = 4'b0101; start = 1'b1;
    for (int k = 1; k <= 30 && d2 == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin a_in = 4'hF; b_in = 4'hF; end
      if (done) begin
        if (d1 == 0) begin
          d1 = k; p1 = product; a_in = 4'b0110; b_in = 4'b0110;
        end else begin
          d2 = k; p2 = product; start = 1'b0;
        end
      end
    end
    total++; if (p1 !== 8'd15) begin bad++; $display("FAIL b2b_prod1 got=%0d want=15", p1); end
    total++; if (p2 !== 8'd36) begin bad++; $display("FAIL b2b_prod2 got=%0d want=36", p2); end
    total++; if (d1 !== 5) begin bad++; $display("FAIL b2b_lat1 got=%0d want=5", d1); end
    total++; if (d2 - d1 !== 6) begin bad++; $display("FAIL b2b_spacing got=%0d want=6", d2 - d1); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [2*W-1:0] p; int lat, nb;
    @(negedge clk); a_in = 4'b1101; b_in = 4'b1011; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, product, add_a, add_b, add_cin} !== '0) begin
      bad++; $display("FAIL async_reset got=%b/%b/%0d/%0h/%0h/%b want all 0",
                      busy, done, product, add_a, add_b, add_cin);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(4'b0010, 4'b0011, 1'b0, p, lat, nb);
    total++; if (p !== 8'd6) begin bad++; $display("FAIL post_reset_prod got=%0d want=6", p); end
    total++; if (lat !== 5) begin bad++; $display("FAIL post_reset_lat got=%0d want=5", lat); end
  endtask

  task automatic test_sweep();
    logic [2*W-1:0] p, exp_p; int lat, nb;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp_p = 8'(a * b);
        run_op(W'(a), W'(b), 1'b0, p, lat, nb);
        total++;
        if (p !== exp_p) begin bad++; $display("FAIL sweep a=%0d b=%0d got=%0d want=%0d", a, b, p, exp_p); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rca_mult_seq.md
Name: rca_mult_seq

Overview:
- Sequencer that uses one external combinational WIDTH-bit ripple-carry adder to do shift-add unsigned multiplication.
- Produces a 2*WIDTH-bit product, one multiplier bit per clock.
- Sits between a requester (start/done handshake) and the RCA cell; owns all operand and accumulator registers.
- The RCA stays purely combinational, and the controller sequences it.

Parameters:
- WIDTH, 4, operand width; matches the RCA width; product is 2*WIDTH bits.
- CNT_W, 3, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  multiplicand, captured on accepted start.
- b_in  input  WIDTH  multiplier, captured on accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  registered result; held until the next accepted start completes.
- add_a  output  WIDTH  RCA operand A.
- add_b  output  WIDTH  RCA operand B.
- add_cin  output  1  RCA carry-in; always 0.
- add_sum  input  WIDTH  RCA sum.
- add_cout  input  1  RCA carry-out.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, product=0, add_a=0, add_b=0, add_cin=0.
  - Internal registers cleared: M, Q, ACC, cnt.
  - Any in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at a clock edge:
  - Capture M=a_in, Q=b_in; ACC=0 (WIDTH bits); cnt=0.
  - Go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC, each cycle:
  - add_a=ACC; add_b = Q[0] ? M : 0; add_cin=0.
  - On the edge: {ACC,Q} <= {add_cout, add_sum, Q} >> 1, i.e. ACC={add_cout, add_sum[WIDTH-1:1]} and Q={add_sum[0], Q[WIDTH-1:1]}.
  - cnt increments.
  - When cnt==WIDTH-1 on the edge, load product={ACC_next,Q_next} and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency:
  - Start accepted at edge T0.
  - busy high during the cycles between T0 and T_WIDTH (WIDTH cycles).
  - done high in the cycle after edge T_WIDTH.
  - Start-to-done is WIDTH+1 cycles; throughput is one op per WIDTH+2 cycles.
- start while in CALC or DONE is ignored, not queued.
  - A start held high continuously is re-accepted in the first IDLE cycle after DONE.
- Outside CALC, add_a and add_b are driven to 0 to suppress adder toggling.
- Unsigned arithmetic only.
  - Carry-out of every add is kept in ACC's MSB via the shift, so there is no overflow: max (2^W-1)^2 fits in 2*WIDTH bits.
- product changes only on the DONE-entry edge; stable otherwise.
- done and busy are never high together.

Decomposition:
- Shared include header holds:
  - state encodings: IDLE=2'd0, CALC=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE;
  - the default WIDTH.
- Natural sub-module rca_mult_dp:
  - M/Q/ACC registers and the shift/mux logic, plus the product register;
  - the FSM and counter stay in rca_mult_seq.
- The RCA itself is instantiated beside this block at the level above, not inside it.

Test Plan:
- a_in=0111, b_in=1001, start pulse -> busy 4 cycles, done pulse at T0+5, product=00111111 (63).
- a_in=1111, b_in=1111 -> product=11100001 (225); checks carry-out capture every iteration.
- a_in=1010, b_in=0000, then a_in=0000, b_in=1101 -> product=0 both times.
  - Also check add_b=0 every CALC cycle of the first op.
- start held high throughout, operands 0011x0101 then 0110x0110 -> products 15 then 36.
  - done pulses 6 cycles apart; start pulses during busy are ignored and operands are not recaptured.
- Assert rst_n=0 two cycles into CALC -> all outputs 0 immediately, asynchronously.
  - After release, a new op 0010x0011 gives product=6 with full WIDTH+1 latency.
- Exhaustive sweep of all 256 a/b pairs with the RCA model attached -> every product equals a*b, done exactly once per start.
